// File: rtl/dcd_pkg.sv
// dcd_pkg -- shared definitions for the programmable Core-B address decoder.
//   * transfer-mode encodings carried on MmMOD
//   * is_load(): true for the modes that present a fresh address
//   * region_t : one decode-table entry (base, compare mask, enable)
package dcd_pkg;

    localparam logic [2:0] MODE_IDLE      = 3'b000;
    localparam logic [2:0] MODE_BUSY      = 3'b001;
    localparam logic [2:0] MODE_LDADDR    = 3'b010;
    localparam logic [2:0] MODE_SEQADDR   = 3'b011;
    localparam logic [2:0] MODE_LDWRPADDR = 3'b110;
    localparam logic [2:0] MODE_WRPADDR   = 3'b111;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] mask;   // 1 = bit takes part in the compare
        logic        en;
    } region_t;

    function automatic logic is_load(input logic [2:0] mode);
        return (mode == MODE_LDADDR) || (mode == MODE_LDWRPADDR);
    endfunction

endpackage

// File: rtl/dcd_prog_if.sv
// dcd_prog_if -- bus and configuration signals of the decoder.
//   master modport : arbiter/bus side plus configuration agent (drives
//                    address, mode, grant, ready and Cfg* strobes)
//   slave modport  : the decoder (drives selects, pending flag, error outputs)
interface dcd_prog_if #(
    parameter int NMST = 16,
    parameter int NSLV = 8,
    parameter int ECW  = 16
);
    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

    logic [31:0]     MmADDR;
    logic [2:0]      MmMOD;
    logic [NMST-1:0] AmCMUX;
    logic            MsRDY;
    logic            CfgWE;
    logic [IW-1:0]   CfgIDX;
    logic [31:0]     CfgBASE;
    logic [31:0]     CfgMASK;
    logic            CfgEN;
    logic            CfgCLR;
    logic [NSLV-1:0] DxSEL;
    logic [NSLV-1:0] DmRMUX;
    logic            CfgPEND;
    logic            DcdERR;
    logic [ECW-1:0]  DcdERRCNT;

    modport master (
        output MmADDR, MmMOD, AmCMUX, MsRDY,
        output CfgWE, CfgIDX, CfgBASE, CfgMASK, CfgEN, CfgCLR,
        input  DxSEL, DmRMUX, CfgPEND, DcdERR, DcdERRCNT
    );

    modport slave (
        input  MmADDR, MmMOD, AmCMUX, MsRDY,
        input  CfgWE, CfgIDX, CfgBASE, CfgMASK, CfgEN, CfgCLR,
        output DxSEL, DmRMUX, CfgPEND, DcdERR, DcdERRCNT
    );

endinterface

// File: rtl/dcd_region_match.sv
// dcd_region_match -- compares one address against one region entry.
//   addr_i  : final (held or live) bus address
//   entry_i : active table entry for this slot
//   hit_o   : entry enabled and every masked bit of addr_i equals base
module dcd_region_match
    import dcd_pkg::*;
(
    input  logic [31:0] addr_i,
    input  region_t     entry_i,
    output logic        hit_o
);

    assign hit_o = entry_i.en && (((addr_i ^ entry_i.base) & entry_i.mask) == 32'h0);

endmodule

// File: rtl/dcd_prog.sv
// dcd_prog -- run-time programmable address decoder for the Core-B bus.
//   CLK, nRST : bus clock, asynchronous active-low reset
//   bus       : dcd_prog_if.slave
//     in  MmADDR/MmMOD/AmCMUX/MsRDY : address, mode, granted master, ready
//     in  Cfg*                      : shadow-table write port, counter clear
//     out DxSEL                     : combinational one-hot slave select
//     out DmRMUX                    : read-mux select, loaded on MsRDY
//     out CfgPEND                   : shadow table differs from active table
//     out DcdERR/DcdERRCNT          : unmapped-access pulse and saturating count
// Slot 0 is the default slave; slots 1..NSLV-1 are programmable regions.
// Table writes land in a shadow copy and are committed as a whole only on an
// IDLE+MsRDY edge, so the map can never change in the middle of a burst.
module dcd_prog
    import dcd_pkg::*;
#(
    parameter int                  NMST      = 16,
    parameter int                  NSLV      = 8,
    parameter logic [NSLV*32-1:0]  INIT_BASE = '0,
    parameter logic [NSLV*32-1:0]  INIT_MASK = '0,
    parameter logic [NSLV-1:0]     INIT_EN   = '0,
    parameter int                  ECW       = 16
) (
    input  logic       CLK,
    input  logic       nRST,
    dcd_prog_if.slave  bus
);

    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

    function automatic region_t init_entry(input int idx);
        region_t e;
        e.base = INIT_BASE[32*idx +: 32];
        e.mask = INIT_MASK[32*idx +: 32];
        e.en   = INIT_EN[idx];
        return e;
    endfunction

    // State
    region_t         shadow_q [1:NSLV-1];
    region_t         shadow_d [1:NSLV-1];
    region_t         active_q [1:NSLV-1];
    region_t         active_d [1:NSLV-1];
    logic [31:0]     l_addr_q, l_addr_d;
    logic            pend_q,   pend_d;
    logic            err_q,    err_d;
    logic [ECW-1:0]  cnt_q,    cnt_d;
    logic [NSLV-1:0] rmux_q,   rmux_d;

    // Decode
    logic            load;
    logic            dft_mst;
    logic [31:0]     final_addr;
    logic [NSLV-1:1] hit;
    logic            any_hit;
    logic [NSLV-1:0] dx_sel;
    logic            commit;
    logic            cfg_acc;
    logic            err_cond;

    assign load       = is_load(bus.MmMOD);
    assign dft_mst    = bus.AmCMUX[0] & ~|bus.AmCMUX[NMST-1:1];
    assign final_addr = load ? bus.MmADDR : l_addr_q;

    for (genvar g = 1; g < NSLV; g++) begin : g_match
        dcd_region_match u_match (
            .addr_i  (final_addr),
            .entry_i (active_q[g]),
            .hit_o   (hit[g])
        );
    end

    // Lowest hitting slot wins; no hit or default master falls back to slot 0.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        dx_sel  = '0;
        any_hit = 1'b0;
        for (int i = 1; i < NSLV; i++) begin
            if (!any_hit && hit[i]) begin
                dx_sel[i] = 1'b1;
                any_hit   = 1'b1;
            end
        end
        if (dft_mst || !any_hit) begin
            dx_sel = NSLV'(1);
        end
    end

    assign commit   = pend_q && (bus.MmMOD == MODE_IDLE) && bus.MsRDY;
    assign err_cond = bus.MsRDY && load && !dft_mst && !any_hit;

    always_comb begin
        shadow_d = shadow_q;
        cfg_acc  = 1'b0;
        // Index 0 and out-of-range indices match no slot and are dropped.
        for (int i = 1; i < NSLV; i++) begin
            if (bus.CfgWE && (bus.CfgIDX == IW'(i))) begin
                shadow_d[i].base = bus.CfgBASE;
                shadow_d[i].mask = bus.CfgMASK;
                shadow_d[i].en   = bus.CfgEN;
                cfg_acc          = 1'b1;
            end
        end

        // Copies shadow_q, i.e. the table before this cycle's write.
        active_d = commit ? shadow_q : active_q;

        if (cfg_acc) begin
            pend_d = 1'b1;
        end else if (commit) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        l_addr_d = load ? bus.MmADDR : l_addr_q;
        rmux_d   = bus.MsRDY ? dx_sel : rmux_q;
        err_d    = err_cond;

        if (bus.CfgCLR) begin
            cnt_d = '0;
        end else if (err_cond && (cnt_q != '1)) begin
            cnt_d = cnt_q + ECW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            // NOTE: the tables are a handful of flops, not a RAM, so they are
            // reset to the INIT map; this also discards uncommitted writes.
            for (int i = 1; i < NSLV; i++) begin
                shadow_q[i] <= init_entry(i);
                active_q[i] <= init_entry(i);
            end
            l_addr_q <= '0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rmux_q   <= NSLV'(1);
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, which is what lets a commit and a shadow write
            // share one edge without the write leaking into the active table.
            shadow_q <= shadow_d;
            active_q <= active_d;
            l_addr_q <= l_addr_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            rmux_q   <= rmux_d;
        end
    end

    assign bus.DxSEL     = dx_sel;
    assign bus.DmRMUX    = rmux_q;
    assign bus.CfgPEND   = pend_q;
    assign bus.DcdERR    = err_q;
    assign bus.DcdERRCNT = cnt_q;

endmodule

// File: tb/tb_dcd_prog.sv
// tb_dcd_prog -- directed self-checking bench for dcd_prog (NSLV=8, ECW=4).
// Reset map: slot 1 = base 0 / mask FFFF_C000 / enabled, all others disabled.
module tb_dcd_prog;
    import dcd_pkg::*;

    localparam int NMST = 16;
    localparam int NSLV = 8;
    localparam int ECW  = 4;
    localparam logic [NSLV*32-1:0] P_BASE = '0;
    localparam logic [NSLV*32-1:0] P_MASK = {192'h0, 32'hFFFF_C000, 32'h0};
    localparam logic [NSLV-1:0]    P_EN   = 8'b0000_0010;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dcd_prog_if #(.NMST(NMST), .NSLV(NSLV), .ECW(ECW)) bus ();

    dcd_prog #(
        .NMST(NMST), .NSLV(NSLV),
        .INIT_BASE(P_BASE), .INIT_MASK(P_MASK), .INIT_EN(P_EN),
        .ECW(ECW)
    ) u_dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_bus(input logic [2:0] mode, input logic [31:0] addr,
                           input logic [15:0] mst, input logic rdy);
        bus.MmMOD  = mode;
        bus.MmADDR = addr;
        bus.AmCMUX = mst;
        bus.MsRDY  = rdy;
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [31:0] base,
                             input logic [31:0] mask, input logic en);
        bus.CfgWE   = 1'b1;
        bus.CfgIDX  = idx;
        bus.CfgBASE = base;
        bus.CfgMASK = mask;
        bus.CfgEN   = en;
    endtask

    task automatic cfg_off();
        bus.CfgWE = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_bus(MODE_IDLE, 32'h0, 16'h0002, 1'b0);
        bus.CfgWE = 1'b0; bus.CfgIDX = '0; bus.CfgBASE = '0;
        bus.CfgMASK = '0; bus.CfgEN = 1'b0; bus.CfgCLR = 1'b0;

        // Reset state
        #12;
        check("rst_rmux",  32'(bus.DmRMUX),    32'h01);
        check("rst_pend",  32'(bus.CfgPEND),   32'h0);
        check("rst_err",   32'(bus.DcdERR),    32'h0);
        check("rst_cnt",   32'(bus.DcdERRCNT), 32'h0);
        check("rst_dxsel", 32'(bus.DxSEL),     32'h02);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic load decode, DmRMUX one edge later
        set_bus(MODE_LDADDR, 32'h0000_1234, 16'h0002, 1'b1);
        #1;
        check("t1_dxsel",     32'(bus.DxSEL),  32'h02);
        check("t1_rmux_pre",  32'(bus.DmRMUX), 32'h01);
        tick();
        check("t1_rmux",      32'(bus.DmRMUX), 32'h02);
        check("t1_err",       32'(bus.DcdERR), 32'h0);

        // Address hold across a sequential burst
        set_bus(MODE_LDADDR, 32'h0000_1000, 16'h0002, 1'b1);
        tick();
        set_bus(MODE_SEQADDR, 32'h0050_0000, 16'h0002, 1'b1);
        #1;
        check("t2_seq_hold", 32'(bus.DxSEL), 32'h02);

        // Program slot 2 mid-burst: pending, no commit until IDLE+MsRDY
        cfg_write(3'd2, 32'h0010_0000, 32'hFFF0_0000, 1'b1);
        tick();
        cfg_off();
        check("t3_pend_set",  32'(bus.CfgPEND), 32'h1);
        check("t3_seq_dxsel", 32'(bus.DxSEL),   32'h02);
        tick();
        check("t3_pend_seq",  32'(bus.CfgPEND), 32'h1);
        set_bus(MODE_LDADDR, 32'h0012_0000, 16'h0002, 1'b0);
        #1;
        check("t3_old_map",   32'(bus.DxSEL),   32'h01);
        tick();
        set_bus(MODE_IDLE, 32'h0, 16'h0002, 1'b0);
        tick();
        check("t3_wait_frz",  32'(bus.CfgPEND), 32'h1);
        set_bus(MODE_IDLE, 32'h0, 16'h0002, 1'b1);
        #1;
        check("t3_precommit", 32'(bus.DxSEL),   32'h01);
        tick();
        check("t3_pend_clr",  32'(bus.CfgPEND), 32'h0);
        check("t3_postcommit",32'(bus.DxSEL),   32'h04);
        set_bus(MODE_LDADDR, 32'h0012_0000, 16'h0002, 1'b1);
        #1;
        check("t3_slot2",     32'(bus.DxSEL),   32'h04);
        tick();
        check("t3_rmux",      32'(bus.DmRMUX),  32'h04);

        // Write colliding with a commit: commit takes the pre-write shadow
        set_bus(MODE_IDLE, 32'h0, 16'h0002, 1'b1);
        cfg_write(3'd3, 32'h0000_0100, 32'h0000_0F00, 1'b1);
        tick();
        cfg_write(3'd4, 32'h4000_0000, 32'hF000_0000, 1'b1);
        tick();
        cfg_off();
        check("t4_pend_keep", 32'(bus.CfgPEND), 32'h1);
        set_bus(MODE_LDADDR, 32'h8000_0100, 16'h0002, 1'b0);
        #1;
        check("t4_slot3",     32'(bus.DxSEL),   32'h08);
        set_bus(MODE_LDADDR, 32'h4000_0000, 16'h0002, 1'b0);
        #1;
        check("t4_slot4_pend",32'(bus.DxSEL),   32'h01);
        set_bus(MODE_LDADDR, 32'h0000_0100, 16'h0002, 1'b0);
        #1;
        check("t4_overlap",   32'(bus.DxSEL),   32'h02);
        set_bus(MODE_IDLE, 32'h0, 16'h0002, 1'b1);
        tick();
        check("t4_pend_clr",  32'(bus.CfgPEND), 32'h0);
        set_bus(MODE_LDADDR, 32'h4000_0000, 16'h0002, 1'b0);
        #1;
        check("t4_slot4",     32'(bus.DxSEL),   32'h10);

        // Unmapped access, default master suppression
        set_bus(MODE_LDADDR, 32'h8000_0000, 16'h0004, 1'b1);
        #1;
        check("t5_unmapped",  32'(bus.DxSEL),     32'h01);
        tick();
        check("t5_err",       32'(bus.DcdERR),    32'h1);
        check("t5_cnt",       32'(bus.DcdERRCNT), 32'h1);
        set_bus(MODE_IDLE, 32'h0, 16'h0004, 1'b1);
        tick();
        check("t5_err_pulse", 32'(bus.DcdERR),    32'h0);
        set_bus(MODE_LDADDR, 32'h8000_0000, 16'h0001, 1'b1);
        tick();
        check("t5_dft_err",   32'(bus.DcdERR),    32'h0);
        check("t5_dft_cnt",   32'(bus.DcdERRCNT), 32'h1);
        set_bus(MODE_LDADDR, 32'h0000_1234, 16'h0001, 1'b0);
        #1;
        check("t5_dft_sel",   32'(bus.DxSEL),     32'h01);
        set_bus(MODE_LDADDR, 32'h0000_1234, 16'h0003, 1'b0);
        #1;
        check("t5_multi_mst", 32'(bus.DxSEL),     32'h02);

        // Wrapping burst holds address
        set_bus(MODE_LDWRPADDR, 32'h0012_0000, 16'h0002, 1'b1);
        #1;
        check("t5_ldwrp",     32'(bus.DxSEL),     32'h04);
        tick();
        set_bus(MODE_WRPADDR, 32'h0000_0000, 16'h0002, 1'b1);
        #1;
        check("t5_wrp_hold",  32'(bus.DxSEL),     32'h04);
        tick();

        // Unmapped load during a wait state is not counted
        set_bus(MODE_LDADDR, 32'h8000_0000, 16'h0002, 1'b0);
        tick();
        check("t5_wait_err",  32'(bus.DcdERR),    32'h0);
        check("t5_wait_cnt",  32'(bus.DcdERRCNT), 32'h1);

        // Saturation, then clear beats increment
        for (int i = 0; i < 20; i++) begin
            set_bus(MODE_LDADDR, 32'h8000_0000 + 32'(i * 16), 16'h0002, 1'b1);
            tick();
        end
        check("t6_sat",       32'(bus.DcdERRCNT), 32'hF);
        set_bus(MODE_LDADDR, 32'h8000_0000, 16'h0002, 1'b1);
        bus.CfgCLR = 1'b1;
        tick();
        bus.CfgCLR = 1'b0;
        check("t6_clr",       32'(bus.DcdERRCNT), 32'h0);
        check("t6_clr_err",   32'(bus.DcdERR),    32'h1);

        // Reset mid-burst discards pending writes
        set_bus(MODE_LDADDR, 32'h0000_1000, 16'h0002, 1'b1);
        cfg_write(3'd5, 32'h2000_0000, 32'hF000_0000, 1'b1);
        tick();
        cfg_off();
        set_bus(MODE_SEQADDR, 32'h0000_1004, 16'h0002, 1'b1);
        check("t7_pend",      32'(bus.CfgPEND),   32'h1);
        check("t7_rmux",      32'(bus.DmRMUX),    32'h02);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_rmux",  32'(bus.DmRMUX),    32'h01);
        check("t7_rst_pend",  32'(bus.CfgPEND),   32'h0);
        check("t7_rst_cnt",   32'(bus.DcdERRCNT), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_bus(MODE_IDLE, 32'h0, 16'h0002, 1'b1);
        tick();
        check("t7_no_commit", 32'(bus.CfgPEND),   32'h0);
        set_bus(MODE_LDADDR, 32'h2000_0000, 16'h0002, 1'b0);
        #1;
        check("t7_lost_wr",   32'(bus.DxSEL),     32'h01);
        set_bus(MODE_LDADDR, 32'h0012_0000, 16'h0002, 1'b0);
        #1;
        check("t7_slot2_gone",32'(bus.DxSEL),     32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcd_prog.md
# dcd_prog

Parametrised, run-time programmable address decoder for the Core-B bus, successor to the fixed-map decoder. It drives one-hot slave selects from a per-slave base/mask region table, holds the address across sequential and wrapping bursts, and registers the read-mux select on `MsRDY`. Table updates go through shadow registers and commit only when the bus is idle. Unmapped accesses are counted. The block sits between the master arbiter (`AmCMUX`) and the slave/read-data muxes.

## Interface
- NMST, 16 — number of masters; bit 0 of `AmCMUX` is the default master.
- NSLV, 8 — number of slave slots; slot 0 is the default slave; slots 1..NSLV-1 are programmable regions.
- INIT_BASE, {NSLV{32'h0}} — packed reset base per slot.
- INIT_MASK, {NSLV{32'h0}} — packed reset mask per slot; 1 = compared bit.
- INIT_EN, 0 — reset enable per slot; bit 0 is ignored.
- ECW, 16 — error counter width.

Ports:
- CLK  in  1  bus clock; single clock domain.
- nRST  in  1  asynchronous, active-low reset.
- MmADDR  in  32  master address.
- MmMOD  in  3  transfer mode: IDLE 000, BUSY 001, LDADDR 010, SEQADDR 011, LDWRPADDR 110, WRPADDR 111.
- AmCMUX  in  NMST  one-hot granted master.
- MsRDY  in  1  slave ready.
- CfgWE  in  1  config write strobe.
- CfgIDX  in  $clog2(NSLV)  slot index being written.
- CfgBASE  in  32  base for the slot.
- CfgMASK  in  32  mask for the slot.
- CfgEN  in  1  enable for the slot.
- CfgCLR  in  1  clear the error counter.
- DxSEL  out  NSLV  combinational one-hot slave select.
- DmRMUX  out  NSLV  registered read-mux select.
- CfgPEND  out  1  shadow table not yet committed.
- DcdERR  out  1  one-cycle unmapped-access pulse.
- DcdERRCNT  out  ECW  saturating count of unmapped accesses.

## Operation
- Default master: `DFT_MST = AmCMUX[0] & ~|AmCMUX[NMST-1:1]`. When it is set, `DxSEL` = slot 0.
- Address hold:
  - On LDADDR or LDWRPADDR, the final address is `MmADDR`, and `MmADDR` is latched into `L_ADDR`.
  - In every other mode, the final address is `L_ADDR`.
- Region hit for slot i (i ≥ 1): `EN[i] && ((FINAL ^ BASE[i]) & MASK[i]) == 0`.
- Priority: the lowest hitting index wins. If no slot hits, select slot 0. `DxSEL` is always exactly one-hot.
- Shadow table:
  - `CfgWE` writes base, mask and enable into shadow slot `CfgIDX`.
  - Writes with `CfgIDX` = 0 or `CfgIDX` ≥ NSLV are ignored.
  - Any accepted write sets `CfgPEND`.
- Commit:
  - The commit condition is `CfgPEND && MmMOD == IDLE && MsRDY` at a clock edge.
  - On commit, the whole shadow table is copied to the active table and `CfgPEND` clears.
  - Decode always uses the active table only.
- Unmapped error:
  - Condition: `MsRDY` && load mode (LDADDR/LDWRPADDR) && !`DFT_MST` && the decode selects slot 0.
  - When the condition holds, `DcdERR` pulses for 1 cycle (registered) and `DcdERRCNT` increments, saturating at all-ones.
  - `CfgCLR` zeroes the counter and has priority over an increment in the same cycle.
- `DmRMUX` loads `DxSEL` on every edge with `MsRDY` = 1 and holds otherwise.

## Timing
- Reset values:
  - `L_ADDR` = 0.
  - Active and shadow tables = INIT_*.
  - `DmRMUX` = 1 (slot 0).
  - `CfgPEND` = 0, `DcdERR` = 0, `DcdERRCNT` = 0.
  - `DxSEL` follows the decode of `L_ADDR` = 0.
- `DxSEL` has zero latency from `MmADDR`/`MmMOD`/`AmCMUX` in load cycles.
- `DmRMUX` has 1-cycle latency, gated by `MsRDY`.
- Wait states (`MsRDY` = 0): `DmRMUX`, the error logic and commit are all frozen. `L_ADDR` still loads in load cycles.
- `CfgWE` in the same cycle as a commit: the commit copies the pre-write shadow, the new write lands in the shadow, and `CfgPEND` stays 1.
- Commit never occurs in BUSY/SEQADDR/WRPADDR or while `MsRDY` = 0, so the map never changes inside a burst.
- A shadow write immediately followed by an IDLE+`MsRDY` cycle is visible in decode on the cycle after that edge.
- Reset asserted mid-burst: all state returns to reset values asynchronously, and pending shadow writes are lost.

## Structure
- Package `dcd_pkg`:
  - mode localparams (IDLE…WRPADDR);
  - `is_load(mode)` function;
  - region-entry struct {base, mask, en}.
- Sub-module `dcd_region_match`: compares one address against one entry and outputs a hit. Instantiate it NSLV-1 times via generate.
- The top level holds the tables, address latch, priority encoder, commit logic, counter and `DmRMUX` register.

## Test plan
- Reset with INIT slot1 = base 0x0000_0000 / mask 0xFFFF_C000 / en 1, then LDADDR 0x0000_1234 with master 1 granted → `DxSEL` = 0x02; `DmRMUX` = 0x02 one edge after `MsRDY`.
- LDADDR 0x0000_1000, then SEQADDR with `MmADDR` = 0x0050_0000 → `DxSEL` stays 0x02 (latched address used).
- Program slot 2 = base 0x0010_0000 / mask 0xFFF0_0000 during a SEQADDR burst → `CfgPEND` = 1 and the old decode holds; on the IDLE+`MsRDY` edge `CfgPEND` = 0; next LDADDR 0x0012_0000 → `DxSEL` = 0x04.
- Overlap: slot 1 and slot 3 both hit 0x0000_0100 → `DxSEL` = 0x02 (lowest index wins).
- LDADDR 0x8000_0000 unmapped, `MsRDY` = 1, master 2 granted → `DxSEL` = 0x01, `DcdERR` pulses 1 cycle, `DcdERRCNT` = 1. Same address with `AmCMUX` = 0x0001 → no error.
- With ECW = 4: 20 unmapped loads → `DcdERRCNT` = 15. `CfgCLR` together with an unmapped load → 0. Assert `nRST` mid-burst → `DmRMUX` = 0x01 and `CfgPEND` = 0.
